clock_divider_ctrl: RTL and testbench

//   Reconfiguration controller for the clock_divider. Two requesters (A: host

---
 rtl/clock_divider_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_clock_divider_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_ctrl.sv
// Reload controller for clock_divider: round-robin arbitration of two scale requesters,
// with the divider reset pulsed only while its output is low so the new scale loads glitch-free.
module clock_divider_ctrl #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned INIT_SCALE    = 1,
    parameter int unsigned RST_CYCLES    = 4,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned TIMEOUT       = 255
) (
    input  logic             clk_in,
    input  logic             nrst,
    input  logic             req_a,
    input  logic [WIDTH-1:0] scale_a,
    output logic             ack_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] scale_b,
    output logic             ack_b,
    input  logic             div_clk,
    output logic [WIDTH-1:0] div_scale,
    output logic             div_nrst,
    output logic             busy
);

    localparam int unsigned      CNT_W       = 8;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] SCALE_RST   = WIDTH'(INIT_SCALE);

    typedef enum logic [2:0] {
        S_INIT     = 3'd0,
        S_IDLE     = 3'd1,
        S_WAIT_LOW = 3'd2,
        S_ASSERT   = 3'd3,
        S_RELEASE  = 3'd4,
        S_ACK      = 3'd5
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             div_clk_meta;
    logic             div_clk_s;
    logic             last_grant;      // 1: B was granted last
    logic             last_grant_nxt;
    logic             grant_b;         // requester currently being served
    logic             grant_b_nxt;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] pending_nxt;
    logic [WIDTH-1:0] div_scale_nxt;
    logic             div_nrst_nxt;
    logic             busy_nxt;
    logic             ack_a_nxt;
    logic             ack_b_nxt;

    logic             any_req_c;
    logic             gnt_b_c;
    logic             req_g_c;
    logic [WIDTH-1:0] gnt_scale_c;

    // Two-flop synchroniser on the fed-back divider output
    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            div_clk_meta <= 1'b0;
            div_clk_s    <= 1'b0;
        end else begin
            div_clk_meta <= div_clk;
            div_clk_s    <= div_clk_meta;
        end
    end

    // Round-robin pick; a tie goes to whoever was not served last
    always_comb begin : arb_comb
        any_req_c = req_a | req_b;
        gnt_b_c   = 1'b0;
        if (req_a && req_b) begin
            gnt_b_c = ~last_grant;
        end else begin
            gnt_b_c = req_b;
        end
        gnt_scale_c = gnt_b_c ? scale_b : scale_a;
        req_g_c     = grant_b ? req_b : req_a;
    end

    // State register and all registered outputs
    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            state      <= S_INIT;
            cnt        <= '0;
            last_grant <= 1'b1;
            grant_b    <= 1'b0;
            pending    <= SCALE_RST;
            div_scale  <= SCALE_RST;
            div_nrst   <= 1'b0;
            busy       <= 1'b1;
            ack_a      <= 1'b0;
            ack_b      <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            last_grant <= last_grant_nxt;
            grant_b    <= grant_b_nxt;
            pending    <= pending_nxt;
            div_scale  <= div_scale_nxt;
            div_nrst   <= div_nrst_nxt;
            busy       <= busy_nxt;
            ack_a      <= ack_a_nxt;
            ack_b      <= ack_b_nxt;
        end
    end

    // Next-state logic
    always_comb begin : next_state_comb
        state_nxt = state;
        case (state)
            S_INIT: begin
                if (cnt == RST_LAST) begin
                    state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (any_req_c) begin
                    if (gnt_scale_c == div_scale) begin
                        state_nxt = S_ACK;
                    end else begin
                        state_nxt = S_WAIT_LOW;
                    end
                end
            end
            S_WAIT_LOW: begin
                // The timeout covers scale 0, where the divider output never reads low
                if (!div_clk_s || (cnt == TMO_LAST)) begin
                    state_nxt = S_ASSERT;
                end
            end
            S_ASSERT: begin
                if (cnt == RST_LAST) begin
                    if (SETTLE_CYCLES == 0) begin
                        state_nxt = S_ACK;
                    end else begin
                        state_nxt = S_RELEASE;
                    end
                end
            end
            S_RELEASE: begin
                if (cnt == SETTLE_LAST) begin
                    state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                if (!req_g_c) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_INIT;
            end
        endcase
    end

    // Next values of counter, grant bookkeeping and outputs
    always_comb begin : out_comb
        cnt_nxt        = cnt;
        last_grant_nxt = last_grant;
        grant_b_nxt    = grant_b;
        pending_nxt    = pending;
        div_scale_nxt  = div_scale;
        div_nrst_nxt   = div_nrst;
        busy_nxt       = (state_nxt != S_IDLE);
        ack_a_nxt      = ack_a;
        ack_b_nxt      = ack_b;

        // Per-state timer: restarts on every transition, saturates otherwise
        if (state_nxt != state) begin
            cnt_nxt = '0;
        end else if (cnt != CNT_MAX) begin
            cnt_nxt = cnt + CNT_W'(1);
        end

        case (state)
            S_INIT: begin
                div_nrst_nxt = (state_nxt == S_IDLE);
            end
            S_IDLE: begin
                div_nrst_nxt = 1'b1;
                if (any_req_c) begin
                    grant_b_nxt    = gnt_b_c;
                    last_grant_nxt = gnt_b_c;
                    pending_nxt    = gnt_scale_c;
                    if (state_nxt == S_ACK) begin
                        ack_a_nxt = ~gnt_b_c;
                        ack_b_nxt = gnt_b_c;
                    end
                end
            end
            S_WAIT_LOW: begin
                // New scale and divider reset land on the same edge
                if (state_nxt == S_ASSERT) begin
                    div_scale_nxt = pending;
                    div_nrst_nxt  = 1'b0;
                end
            end
            S_ASSERT: begin
                if (state_nxt != S_ASSERT) begin
                    div_nrst_nxt = 1'b1;
                    if (state_nxt == S_ACK) begin
                        ack_a_nxt = ~grant_b;
                        ack_b_nxt = grant_b;
                    end
                end
            end
            S_RELEASE: begin
                if (state_nxt == S_ACK) begin
                    ack_a_nxt = ~grant_b;
                    ack_b_nxt = grant_b;
                end
            end
            S_ACK: begin
                if (state_nxt == S_IDLE) begin
                    ack_a_nxt = 1'b0;
                    ack_b_nxt = 1'b0;
                end
            end
            default: begin
                div_nrst_nxt = 1'b0;
                ack_a_nxt    = 1'b0;
                ack_b_nxt    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// Bench for clock_divider_ctrl: per-cycle comparison against a transaction-timeline model,
// directed scenarios with hand-computed expectations, then randomized two-requester traffic.
module tb_clock_divider_ctrl;

    localparam int WIDTH         = 8;
    localparam int INIT_SCALE    = 1;
    localparam int RST_CYCLES    = 4;
    localparam int SETTLE_CYCLES = 2;
    localparam int TIMEOUT       = 255;

    logic             clk_in  = 1'b0;
    logic             nrst    = 1'b1;
    logic             req_a   = 1'b0;
    logic             req_b   = 1'b0;
    logic [WIDTH-1:0] scale_a = '0;
    logic [WIDTH-1:0] scale_b = '0;
    logic             div_clk = 1'b0;
    logic             ack_a;
    logic             ack_b;
    logic [WIDTH-1:0] div_scale;
    logic             div_nrst;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;
    int dmode    = 0;

    clock_divider_ctrl #(
        .WIDTH        (WIDTH),
        .INIT_SCALE   (INIT_SCALE),
        .RST_CYCLES   (RST_CYCLES),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clk_in   (clk_in),
        .nrst     (nrst),
        .req_a    (req_a),
        .scale_a  (scale_a),
        .ack_a    (ack_a),
        .req_b    (req_b),
        .scale_b  (scale_b),
        .ack_b    (ack_b),
        .div_clk  (div_clk),
        .div_scale(div_scale),
        .div_nrst (div_nrst),
        .busy     (busy)
    );

    always #5 clk_in = ~clk_in;

    // ---------------- reference model ----------------
    logic [WIDTH-1:0] m_scale;
    logic             m_nrst;
    logic             m_busy;
    logic             m_ack_a;
    logic             m_ack_b;
    logic             h1;
    logic             h2;

    task automatic set_reset_exp();
        m_scale = WIDTH'(INIT_SCALE);
        m_nrst  = 1'b0;
        m_busy  = 1'b1;
        m_ack_a = 1'b0;
        m_ack_b = 1'b0;
        h1      = 1'b0;
        h2      = 1'b0;
    endtask

    // One clock of model time; ok=0 means an async reset cut the timeline short
    task automatic tick(output logic ok, output logic sync);
        @(posedge clk_in or negedge nrst);
        if (!nrst) begin
            set_reset_exp();
            ok   = 1'b0;
            sync = 1'b0;
        end else begin
            ok   = 1'b1;
            sync = h2;
            h2   = h1;
            h1   = div_clk;
        end
    endtask

    initial begin : model
        logic             ok;
        logic             s;
        logic             lg;
        logic             gb;
        logic [WIDTH-1:0] pend;
        int               n;
        set_reset_exp();
        forever begin
            wait (nrst === 1'b1);
            lg = 1'b1;
            ok = 1'b1;
            for (int i = 0; i < RST_CYCLES; i++) begin
                tick(ok, s);
                if (!ok) break;
            end
            if (ok) begin
                m_nrst = 1'b1;
                m_busy = 1'b0;
            end
            while (ok) begin
                forever begin
                    tick(ok, s);
                    if (!ok || req_a || req_b) break;
                end
                if (!ok) break;
                gb     = (req_a && req_b) ? ~lg : req_b;
                lg     = gb;
                pend   = gb ? scale_b : scale_a;
                m_busy = 1'b1;
                if (pend != m_scale) begin
                    n = 0;
                    forever begin
                        tick(ok, s);
                        if (!ok || !s || n == TIMEOUT - 1) break;
                        n++;
                    end
                    if (!ok) break;
                    m_scale = pend;
                    m_nrst  = 1'b0;
                    for (int i = 0; i < RST_CYCLES; i++) begin
                        tick(ok, s);
                        if (!ok) break;
                    end
                    if (!ok) break;
                    m_nrst = 1'b1;
                    for (int i = 0; i < SETTLE_CYCLES; i++) begin
                        tick(ok, s);
                        if (!ok) break;
                    end
                    if (!ok) break;
                end
                if (gb) m_ack_b = 1'b1;
                else    m_ack_a = 1'b1;
                forever begin
                    tick(ok, s);
                    if (!ok || !(gb ? req_b : req_a)) break;
                end
                if (!ok) break;
                m_ack_a = 1'b0;
                m_ack_b = 1'b0;
                m_busy  = 1'b0;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic cyc(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk_in);
            #2;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return div_nrst;
            1:       return ack_a;
            2:       return ack_b;
            3:       return busy;
            default: return ack_a | ack_b;
        endcase
    endfunction

    task automatic wait_until(input int sel, input logic val, input int budget,
                              input string name, output int used);
        used = 0;
        while (sig(sel) !== val && used < budget) begin
            cyc(1);
            used++;
        end
        if (sig(sel) !== val) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: still %b after %0d cycles, wanted %b", name, sig(sel), used, val);
        end
    endtask

    task automatic drive(input logic is_b, input logic r, input logic [WIDTH-1:0] s);
        if (is_b) begin
            req_b   = r;
            scale_b = s;
        end else begin
            req_a   = r;
            scale_a = s;
        end
    endtask

    task automatic requester(input logic is_b, input int n_tx);
        int               used;
        logic [WIDTH-1:0] sc;
        for (int t = 0; t < n_tx; t++) begin
            cyc(int'($urandom_range(0, 6)));
            if (!is_b) dmode = int'($urandom_range(0, 3));
            sc = ($urandom_range(0, 3) == 0) ? div_scale : WIDTH'($urandom_range(1, 15));
            drive(is_b, 1'b1, sc);
            if ($urandom_range(0, 1) == 1) begin
                cyc(1);
                drive(is_b, 1'b1, WIDTH'($urandom_range(1, 15)));
            end
            wait_until(is_b ? 2 : 1, 1'b1, 1500, is_b ? "rnd_ack_b_rise" : "rnd_ack_a_rise", used);
            cyc(int'($urandom_range(0, 3)));
            drive(is_b, 1'b0, is_b ? scale_b : scale_a);
            wait_until(is_b ? 2 : 1, 1'b0, 5, is_b ? "rnd_ack_b_fall" : "rnd_ack_a_fall", used);
        end
    endtask

    // ---------------- stimulus and checking ----------------
    initial begin : main
        int used;
        int lowc;
        #1 nrst = 1'b0;
        fork
            forever begin
                @(negedge clk_in);
                n_checks++;
                if ({div_scale, div_nrst, busy, ack_a, ack_b} !==
                    {m_scale, m_nrst, m_busy, m_ack_a, m_ack_b}) begin
                    n_fail++;
                    $display("FAIL cycle_compare @%0t: dut scale=%0d nrst=%b busy=%b ack_a=%b ack_b=%b, model scale=%0d nrst=%b busy=%b ack_a=%b ack_b=%b",
                             $time, div_scale, div_nrst, busy, ack_a, ack_b,
                             m_scale, m_nrst, m_busy, m_ack_a, m_ack_b);
                end
            end
            begin : divgen
                int dcnt;
                dcnt = 0;
                forever begin
                    @(posedge clk_in);
                    #2;
                    case (dmode)
                        0: begin
                            dcnt++;
                            if (dcnt >= 3) begin
                                dcnt    = 0;
                                div_clk = ~div_clk;
                            end
                        end
                        1:       div_clk = 1'b1;
                        2:       div_clk = 1'b0;
                        default: div_clk = 1'($urandom_range(0, 1));
                    endcase
                end
            end
        join_none

        // Reset values
        cyc(3);
        chk("reset_outputs", 32'({div_scale, div_nrst, busy, ack_a, ack_b}), 32'({8'd1, 4'b0100}));

        // 1: INIT holds div_nrst low for four cycles
        nrst = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            cyc(1);
            chk("t1_div_nrst", 32'(div_nrst), 32'(k >= 4));
        end
        chk("t1_idle", 32'({div_scale, busy, ack_a, ack_b}), 32'({8'd1, 3'b000}));

        // 2: single reload from A
        scale_a = 8'd3;
        req_a   = 1'b1;
        wait_until(0, 1'b0, 50, "t2_nrst_fall", used);
        chk("t2_scale_at_assert", 32'(div_scale), 32'd3);
        lowc = 0;
        while (div_nrst == 1'b0 && lowc < 20) begin
            cyc(1);
            lowc++;
        end
        chk("t2_nrst_low_cycles", 32'(lowc), 32'd4);
        wait_until(1, 1'b1, 10, "t2_ack_a", used);
        chk("t2_ack_after_release", 32'(used), 32'd2);
        cyc(3);
        chk("t2_ack_held", 32'(ack_a), 32'd1);
        req_a = 1'b0;
        cyc(1);
        chk("t2_ack_drop", 32'({ack_a, busy}), 32'd0);

        // 4: scale already loaded, acknowledged without a reload
        scale_b = 8'd3;
        req_b   = 1'b1;
        wait_until(2, 1'b1, 10, "t4_ack_b", used);
        chk("t4_ack_latency", 32'(used), 32'd1);
        chk("t4_no_reload", 32'({div_nrst, div_scale}), 32'({1'b1, 8'd3}));
        req_b = 1'b0;
        cyc(1);
        chk("t4_ack_drop", 32'(ack_b), 32'd0);

        // 3: tie after B was served last -> A first, then B, next tie A again
        scale_a = 8'd5;
        scale_b = 8'd7;
        req_a   = 1'b1;
        req_b   = 1'b1;
        wait_until(4, 1'b1, 400, "t3_first_ack", used);
        chk("t3_first_is_a", 32'({ack_a, ack_b}), 32'b10);
        chk("t3_scale_a", 32'(div_scale), 32'd5);
        req_a = 1'b0;
        wait_until(2, 1'b1, 400, "t3_ack_b", used);
        chk("t3_scale_b", 32'(div_scale), 32'd7);
        req_b = 1'b0;
        cyc(2);
        scale_a = 8'd9;
        scale_b = 8'd11;
        req_a   = 1'b1;
        req_b   = 1'b1;
        wait_until(4, 1'b1, 400, "t3_second_tie", used);
        chk("t3_second_tie_is_a", 32'({ack_a, ack_b}), 32'b10);
        req_a = 1'b0;
        wait_until(2, 1'b1, 400, "t3_second_ack_b", used);
        chk("t3_second_scale_b", 32'(div_scale), 32'd11);
        req_b = 1'b0;
        cyc(2);

        // 5: divider output stuck high, reload forced by the timeout
        dmode = 1;
        cyc(4);
        scale_a = 8'd0;
        req_a   = 1'b1;
        wait_until(3, 1'b1, 5, "t5_busy", used);
        wait_until(0, 1'b0, 300, "t5_nrst_fall", used);
        chk("t5_timeout_cycles", 32'(used), 32'd255);
        chk("t5_scale_zero", 32'(div_scale), 32'd0);
        wait_until(1, 1'b1, 20, "t5_ack_a", used);
        req_a = 1'b0;
        wait_until(1, 1'b0, 5, "t5_ack_drop", used);
        cyc(2);

        // 6: reset during ASSERT, request is re-arbitrated after INIT
        dmode   = 0;
        scale_a = 8'd9;
        req_a   = 1'b1;
        wait_until(0, 1'b0, 50, "t6_nrst_fall", used);
        cyc(1);
        nrst = 1'b0;
        #1;
        chk("t6_async_reset", 32'({div_scale, div_nrst, busy, ack_a, ack_b}), 32'({8'd1, 4'b0100}));
        cyc(2);
        nrst = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cyc(1);
            chk("t6_init_nrst", 32'(div_nrst), 32'(k >= 4));
        end
        wait_until(1, 1'b1, 400, "t6_ack_a", used);
        chk("t6_scale_after_reset", 32'(div_scale), 32'd9);
        req_a = 1'b0;
        wait_until(1, 1'b0, 5, "t6_ack_drop", used);
        cyc(2);

        // Request withdrawn mid-reload still completes with a one-cycle ack
        scale_a = 8'd20;
        req_a   = 1'b1;
        wait_until(0, 1'b0, 50, "t7_nrst_fall", used);
        req_a = 1'b0;
        wait_until(1, 1'b1, 20, "t7_ack_a", used);
        chk("t7_scale", 32'(div_scale), 32'd20);
        cyc(1);
        chk("t7_ack_pulse", 32'({ack_a, busy}), 32'd0);
        cyc(2);

        // Randomized traffic from both requesters
        fork
            requester(1'b0, 25);
            requester(1'b1, 25);
        join
        req_a = 1'b0;
        req_b = 1'b0;
        cyc(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
